// File: rtl/ins_fetch_unit.sv
// Instruction fetch unit: instruction memory, program counter and a prefetch
// FIFO that streams instructions to the decoder over valid/ready.
// Optional hardware zero-overhead loop is enabled by defining IFU_LOOP_EN.
module ins_fetch_unit #(
  parameter int                      INS_ADDR_WIDTH = 8,
  parameter int                      INS_WIDTH      = 64,
  parameter int                      OPCODE_WIDTH   = 3,
  parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE    = 3'b111,
  parameter int                      FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [INS_ADDR_WIDTH-1:0] start_pc,
  input  logic                      redirect,
  input  logic [INS_ADDR_WIDTH-1:0] redirect_pc,
  input  logic                      load_we,
  input  logic [INS_ADDR_WIDTH-1:0] load_addr,
  input  logic [INS_WIDTH-1:0]      load_data,
`ifdef IFU_LOOP_EN
  input  logic [INS_ADDR_WIDTH-1:0] loop_start,
  input  logic [INS_ADDR_WIDTH-1:0] loop_end,
  input  logic [15:0]               loop_count,
`endif
  output logic                      ins_valid,
  input  logic                      ins_ready,
  output logic [INS_WIDTH-1:0]      ins_data,
  output logic [INS_ADDR_WIDTH-1:0] ins_pc,
  output logic                      busy,
  output logic                      halted
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALTED} state_t;

  state_t                    state_q, state_d;
  logic [INS_ADDR_WIDTH-1:0] pc_p0, pc_d;
  logic                      vld_p1;
  logic [INS_WIDTH-1:0]      data_p1;
  logic [INS_ADDR_WIDTH-1:0] pc_p1;
  logic [INS_WIDTH-1:0]      imem [0:(1<<INS_ADDR_WIDTH)-1];
  logic [INS_WIDTH-1:0]      fifo_data [0:FIFO_DEPTH-1];
  logic [INS_ADDR_WIDTH-1:0] fifo_pc [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [CNT_W:0]            occ;
  logic                      start_ok, redir_ok, halt_word, enq, deq, issue;
  logic                      loop_take;
  logic [INS_ADDR_WIDTH-1:0] loop_target;

  // Accepted commands: start only when stopped, redirect only while running.
  assign start_ok  = start && (state_q == S_IDLE || state_q == S_HALTED);
  assign redir_ok  = redirect && (state_q == S_FETCH || state_q == S_DRAIN);

  // A returning halt word is consumed here and never reaches the FIFO.
  assign halt_word = vld_p1 && (data_p1[INS_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);
  assign enq       = vld_p1 && !halt_word && !redir_ok;
  assign deq       = ins_valid && ins_ready && !redir_ok;

  // Reserve a FIFO slot for every read in flight so the FIFO can never overflow.
  assign occ   = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign issue = (state_q == S_FETCH) && !redir_ok && !halt_word &&
                 (occ < (CNT_W+1)'(FIFO_DEPTH));

`ifdef IFU_LOOP_EN
  logic [INS_ADDR_WIDTH-1:0] loop_start_q, loop_end_q;
  logic [15:0]               remaining_q;

  assign loop_take   = issue && (pc_p0 == loop_end_q) && (remaining_q != 16'd0);
  assign loop_target = loop_start_q;

  // Loop iteration counter: loaded on start, cleared by redirect, spent per jump back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q <= 16'd0;
    end else if (start_ok) begin
      remaining_q <= loop_count;
    end else if (redir_ok) begin
      remaining_q <= 16'd0;
    end else if (loop_take) begin
      remaining_q <= remaining_q - 16'd1;
    end
  end

  // Loop bounds captured with the start command.
  always_ff @(posedge clk) begin
    if (start_ok) begin
      loop_start_q <= loop_start;
      loop_end_q   <= loop_end;
    end
  end
`else
  assign loop_take   = 1'b0;
  assign loop_target = pc_p0;
`endif

  // Next PC: start and redirect load it, each issued read advances it.
  always_comb begin
    pc_d = pc_p0;
    if (start_ok) begin
      pc_d = start_pc;
    end else if (redir_ok) begin
      pc_d = redirect_pc;
    end else if (loop_take) begin
      pc_d = loop_target;
    end else if (issue) begin
      pc_d = pc_p0 + INS_ADDR_WIDTH'(1);
    end
  end

  // Next state: redirect wins over halt detection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: if (start_ok) state_d = S_FETCH;
      S_FETCH: begin
        if (redir_ok)       state_d = S_FETCH;
        else if (halt_word) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redir_ok)            state_d = S_FETCH;
        else if (count == '0)    state_d = S_HALTED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // p0 -> p1: PC, read-in-flight flag and FIFO occupancy; redirect flushes all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_p0  <= '0;
      vld_p1 <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      pc_p0  <= pc_d;
      vld_p1 <= issue;
      if (redir_ok) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
        if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // Instruction memory: read-first synchronous read feeding the p1 data stage.
  always_ff @(posedge clk) begin
    if (load_we) imem[load_addr] <= load_data;
    if (issue) begin
      data_p1 <= imem[pc_p0];
      pc_p1   <= pc_p0;
    end
  end

  // p1 -> FIFO: returned words are queued with their PC.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_data[wr_ptr] <= data_p1;
      fifo_pc[wr_ptr]   <= pc_p1;
    end
  end

  assign ins_valid = (count != '0);
  assign ins_data  = ins_valid ? fifo_data[rd_ptr] : '0;
  assign ins_pc    = ins_valid ? fifo_pc[rd_ptr]   : '0;
  assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Self-checking bench for ins_fetch_unit (default parameters).
module tb_ins_fetch_unit;
  localparam int AW = 8;
  localparam int IW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          load_we = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic          ins_ready = 1'b0;
  logic          ins_valid;
  logic [IW-1:0] ins_data;
  logic [AW-1:0] ins_pc;
  logic          busy, halted;
`ifdef IFU_LOOP_EN
  logic [AW-1:0] loop_start = '0;
  logic [AW-1:0] loop_end = '0;
  logic [15:0]   loop_count = '0;
`endif

  ins_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
`ifdef IFU_LOOP_EN
    .loop_start(loop_start), .loop_end(loop_end), .loop_count(loop_count),
`endif
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_data(ins_data),
    .ins_pc(ins_pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] mem_m [256];
  logic [AW-1:0] got_pc [$];
  logic [IW-1:0] got_data [$];

  typedef struct {
    logic [AW-1:0] spc;
    logic [AW-1:0] halt_a;
    int            n;
    logic [AW-1:0] first;
    logic [AW-1:0] last;
  } vec_t;

  function automatic logic [IW-1:0] tag(input logic [AW-1:0] a, input logic [7:0] g);
    return {3'b010, 45'h0, g, a};
  endfunction

  function automatic logic [IW-1:0] halt_w(input logic [AW-1:0] a);
    return {3'b111, 53'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    tick;
    load_we = 1'b0;
    mem_m[a] = d;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic pulse_start(input logic [AW-1:0] p);
    start_pc = p; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Consume instructions until halted (bounded), optionally with random back-pressure.
  task automatic run_collect(input int budget, input bit rnd);
    int cyc;
    bit hold, r;
    logic [IW-1:0] hd;
    logic [AW-1:0] hp;
    got_pc.delete(); got_data.delete();
    hold = 1'b0; cyc = 0; hd = '0; hp = '0;
    while (halted !== 1'b1 && cyc < budget) begin
      if (hold) begin
        chk("hold_valid", 64'(ins_valid), 64'd1);
        chk("hold_data", ins_data, hd);
        chk("hold_pc", 64'(ins_pc), 64'(hp));
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ins_ready = r;
      if (ins_valid && r) begin
        got_pc.push_back(ins_pc);
        got_data.push_back(ins_data);
      end
      hold = ins_valid && !r; hd = ins_data; hp = ins_pc;
      tick;
      cyc++;
    end
    ins_ready = 1'b0;
    chk("halt_reached", 64'(halted), 64'd1);
  endtask

  initial begin
    vec_t tbl [4];
    logic [AW-1:0] exp_pc [$];
    logic [IW-1:0] exp_data [$];
    logic [AW-1:0] a;
    int L;

    // Reset state, checked while reset is held and after release.
    @(negedge clk);
    chk("rst_valid", 64'(ins_valid), 64'd0);
    chk("rst_data", ins_data, 64'd0);
    chk("rst_pc", 64'(ins_pc), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    rst = 1'b0;
    tick;
    chk("idle_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 256; i++) load_word(AW'(i), tag(AW'(i), 8'h00));

    // Program A,B,C,HALT with exact latency and back-to-back delivery.
    load_word(0, tag(0, 8'hA1)); load_word(1, tag(1, 8'hB2));
    load_word(2, tag(2, 8'hC3)); load_word(3, halt_w(3));
    ins_ready = 1'b1;
    pulse_start(0);
    chk("t1_c0_valid", 64'(ins_valid), 64'd0);
    tick;
    chk("t1_c1_valid", 64'(ins_valid), 64'd0);
    chk("t1_c1_busy", 64'(busy), 64'd1);
    tick;
    chk("t1_c2_valid", 64'(ins_valid), 64'd1);
    chk("t1_c2_pc", 64'(ins_pc), 64'd0);
    chk("t1_c2_data", ins_data, tag(0, 8'hA1));
    tick;
    chk("t1_c3_pc", 64'(ins_pc), 64'd1);
    chk("t1_c3_data", ins_data, tag(1, 8'hB2));
    tick;
    chk("t1_c4_pc", 64'(ins_pc), 64'd2);
    chk("t1_c4_data", ins_data, tag(2, 8'hC3));
    tick;
    chk("t1_c5_valid", 64'(ins_valid), 64'd0);
    tick;
    chk("t1_halted", 64'(halted), 64'd1);
    chk("t1_busy", 64'(busy), 64'd0);

    // Same program with the decoder stalled for 10 cycles.
    do_reset;
    ins_ready = 1'b0;
    pulse_start(0);
    tick; tick;
    for (int i = 0; i < 10; i++) begin
      chk("t2_stall_valid", 64'(ins_valid), 64'd1);
      chk("t2_stall_pc", 64'(ins_pc), 64'd0);
      chk("t2_stall_data", ins_data, tag(0, 8'hA1));
      tick;
    end
    run_collect(50, 1'b0);
    chk("t2_count", 64'(got_pc.size()), 64'd3);
    if (got_pc.size() == 3) begin
      chk("t2_d0", got_data[0], tag(0, 8'hA1));
      chk("t2_d1", got_data[1], tag(1, 8'hB2));
      chk("t2_d2", got_data[2], tag(2, 8'hC3));
    end

    // Redirect with three entries queued and a transfer offered in the same cycle.
    load_word(5, tag(5, 8'hC5)); load_word(6, tag(6, 8'hC6));
    do_reset;
    ins_ready = 1'b0;
    pulse_start(20);
    tick; tick; tick; tick;
    chk("t3_pre_valid", 64'(ins_valid), 64'd1);
    chk("t3_pre_pc", 64'(ins_pc), 64'd20);
    redirect = 1'b1; redirect_pc = 5; ins_ready = 1'b1;
    tick;
    redirect = 1'b0;
    chk("t3_flush_valid", 64'(ins_valid), 64'd0);
    tick;
    chk("t3_gap_valid", 64'(ins_valid), 64'd0);
    tick;
    chk("t3_x_valid", 64'(ins_valid), 64'd1);
    chk("t3_x_pc", 64'(ins_pc), 64'd5);
    chk("t3_x_data", ins_data, tag(5, 8'hC5));
    tick;
    chk("t3_y_pc", 64'(ins_pc), 64'd6);
    chk("t3_y_data", ins_data, tag(6, 8'hC6));

    // Asynchronous reset in the middle of a run.
    ins_ready = 1'b0;
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(ins_valid), 64'd0);
    chk("mid_rst_data", ins_data, 64'd0);
    chk("mid_rst_pc", 64'(ins_pc), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick;
    chk("mid_rst_idle", 64'(busy), 64'd0);

    // Write to the word being read in the same cycle: old word first, new on re-run.
    load_word(7, tag(7, 8'h01)); load_word(8, halt_w(8));
    do_reset;
    pulse_start(7);
    load_we = 1'b1; load_addr = 7; load_data = tag(7, 8'h02);
    tick;
    load_we = 1'b0;
    mem_m[7] = tag(7, 8'h02);
    run_collect(50, 1'b0);
    chk("t5_old_n", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) chk("t5_old", got_data[0], tag(7, 8'h01));
    pulse_start(7);
    run_collect(50, 1'b0);
    chk("t5_new_n", 64'(got_data.size()), 64'd1);
    if (got_data.size() > 0) chk("t5_new", got_data[0], tag(7, 8'h02));

    // Table-driven programs: start address, halt address, expected count and PC range.
    tbl[0] = '{spc: 8'd0,   halt_a: 8'd3,   n: 3, first: 8'd0,   last: 8'd2};
    tbl[1] = '{spc: 8'd254, halt_a: 8'd1,   n: 3, first: 8'd254, last: 8'd0};
    tbl[2] = '{spc: 8'd40,  halt_a: 8'd40,  n: 0, first: 8'd0,   last: 8'd0};
    tbl[3] = '{spc: 8'd100, halt_a: 8'd105, n: 5, first: 8'd100, last: 8'd104};
    for (int k = 0; k < 4; k++) begin
      a = tbl[k].spc;
      while (a != tbl[k].halt_a) begin
        load_word(a, tag(a, 8'(k + 16)));
        a = a + 1'b1;
      end
      load_word(tbl[k].halt_a, halt_w(tbl[k].halt_a));
      do_reset;
      pulse_start(tbl[k].spc);
      run_collect(100, 1'b0);
      chk("tbl_n", 64'(got_pc.size()), 64'(tbl[k].n));
      if (tbl[k].n > 0 && got_pc.size() > 0) begin
        chk("tbl_first", 64'(got_pc[0]), 64'(tbl[k].first));
        chk("tbl_last", 64'(got_pc[got_pc.size()-1]), 64'(tbl[k].last));
      end
      for (int i = 0; i < got_pc.size(); i++) chk("tbl_data", got_data[i], mem_m[got_pc[i]]);
      chk("tbl_busy", 64'(busy), 64'd0);
    end

`ifdef IFU_LOOP_EN
    // Hardware loop over addresses 1..2, two extra passes.
    load_word(0, tag(0, 8'h70)); load_word(1, tag(1, 8'h71));
    load_word(2, tag(2, 8'h72)); load_word(3, halt_w(3));
    do_reset;
    loop_start = 1; loop_end = 2; loop_count = 16'd2;
    pulse_start(0);
    loop_count = 16'd0;
    run_collect(100, 1'b1);
    exp_pc = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    chk("loop_n", 64'(got_pc.size()), 64'(exp_pc.size()));
    for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
      chk("loop_pc", 64'(got_pc[i]), 64'(exp_pc[i]));
      chk("loop_data", got_data[i], mem_m[exp_pc[i]]);
    end
`endif

    // Random programs under random back-pressure versus a memory-walk model.
    for (int it = 0; it < 8; it++) begin
      a = AW'($urandom_range(0, 255));
      L = $urandom_range(1, 12);
      for (int j = 0; j < L; j++)
        load_word(a + AW'(j), {3'($urandom_range(0, 6)), 61'({$urandom, $urandom})});
      load_word(a + AW'(L), halt_w(a + AW'(L)));
      exp_pc.delete(); exp_data.delete();
      begin
        logic [AW-1:0] p;
        p = a;
        for (int s = 0; s < 256; s++) begin
          if (mem_m[p][IW-1 -: 3] == 3'b111) break;
          exp_pc.push_back(p);
          exp_data.push_back(mem_m[p]);
          p = p + 1'b1;
        end
      end
      do_reset;
      pulse_start(a);
      run_collect(400, 1'b1);
      chk("rnd_n", 64'(got_pc.size()), 64'(exp_pc.size()));
      for (int i = 0; i < got_pc.size() && i < exp_pc.size(); i++) begin
        chk("rnd_pc", 64'(got_pc[i]), 64'(exp_pc[i]));
        chk("rnd_data", got_data[i], exp_data[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
